// File: rtl/turn_timer_ctrl.sv
// turn_timer_ctrl: two-player turn timer.
// Owns a per-second prescaler and a turn countdown. The active player is
// toggled on each completed move or acknowledged expiry. All outputs are
// registered. The reset deassertion is synchronised to C_50Mhz.
// Optional feature macro: TURN_TIMER_BLINK_EN. It enables the low-time
// warning blink. Without it, blink is tied high.
//
// state   | meaning
// --------+---------------------------------------------
// IDLE    | waiting for start
// RUN     | countdown active
// PAUSED  | pause held high, prescaler and secs frozen
// EXPIRED | turn timed out, waiting for ack
module turn_timer_ctrl #(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int TURN_SECS     = 30
) (
  input  logic       C_50Mhz,
  input  logic       rst_n,
  input  logic       start,
  input  logic       move_done,
  input  logic       pause,
  input  logic       abort,
  input  logic       ack,
  output logic       player,
  output logic [5:0] secs_left,
  output logic       sec_tick,
  output logic       timeUp,
  output logic       running,
  output logic       blink
);

  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICKS_PER_SEC - 1);
  localparam logic [5:0]    TURN    = 6'(TURN_SECS);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

  state_t        state, nxt_state;
  logic [PW-1:0] pre, nxt_pre;
  logic          nxt_player;
  logic [5:0]    nxt_secs;
  logic          nxt_tick, nxt_tu;
  logic          rst_meta, rst_sync_n;

  // Reset asserts immediately and deasserts two clock edges later.
  always_ff @(posedge C_50Mhz or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta   <= 1'b0;
      rst_sync_n <= 1'b0;
    end else begin
      rst_meta   <= 1'b1;
      rst_sync_n <= rst_meta;
    end
  end

  // Next-state and next-output decode. Same-edge priority is:
  // abort, then move_done, then pause, then the prescaler tick.
  always_comb begin
    nxt_state  = state;
    nxt_pre    = pre;
    nxt_player = player;
    nxt_secs   = secs_left;
    nxt_tick   = 1'b0;
    nxt_tu     = 1'b0;
    if (abort) begin
      nxt_state  = IDLE;
      nxt_pre    = '0;
      nxt_player = 1'b0;
      nxt_secs   = TURN;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            nxt_state  = RUN;
            nxt_pre    = '0;
            nxt_player = 1'b0;
            nxt_secs   = TURN;
          end
        end
        RUN, PAUSED: begin
          if (move_done) begin
            // The state is kept, so a move made while paused stays paused.
            nxt_player = ~player;
            nxt_secs   = TURN;
            nxt_pre    = '0;
          end else if (pause) begin
            nxt_state = PAUSED;
          end else begin
            // The edge that releases pause also counts. A pause therefore
            // costs exactly the number of cycles it was held high.
            nxt_state = RUN;
            if (pre == PRE_MAX) begin
              nxt_pre  = '0;
              nxt_tick = 1'b1;
              nxt_secs = secs_left - 6'd1;
              if (secs_left == 6'd1) begin
                nxt_tu    = 1'b1;
                nxt_state = EXPIRED;
              end
            end else begin
              nxt_pre = pre + PW'(1);
            end
          end
        end
        EXPIRED: begin
          if (ack) begin
            nxt_state  = RUN;
            nxt_player = ~player;
            nxt_secs   = TURN;
            nxt_pre    = '0;
          end
        end
        default: nxt_state = IDLE;
      endcase
    end
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge C_50Mhz or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state     <= IDLE;
      pre       <= '0;
      player    <= 1'b0;
      secs_left <= TURN;
      sec_tick  <= 1'b0;
      timeUp    <= 1'b0;
      running   <= 1'b0;
    end else begin
      state     <= nxt_state;
      pre       <= nxt_pre;
      player    <= nxt_player;
      secs_left <= nxt_secs;
      sec_tick  <= nxt_tick;
      timeUp    <= nxt_tu;
      running   <= (nxt_state == RUN) || (nxt_state == PAUSED);
    end
  end

`ifdef TURN_TIMER_BLINK_EN
  localparam logic [PW-1:0] PRE_HALF = PW'(TICKS_PER_SEC / 2);
  logic nxt_blink;

  // Blink is derived from next-cycle values, so it lines up with the
  // registered prescaler.
  always_comb begin
    nxt_blink = 1'b1;
    if (nxt_state == EXPIRED)
      nxt_blink = 1'b0;
    else if (nxt_state == RUN && nxt_secs <= 6'd5)
      nxt_blink = (nxt_pre < PRE_HALF);
  end

  // Registered warning blink.
  always_ff @(posedge C_50Mhz or negedge rst_sync_n) begin
    if (!rst_sync_n) blink <= 1'b1;
    else             blink <= nxt_blink;
  end
`else
  assign blink = 1'b1;
`endif

endmodule

// File: doc/turn_timer_ctrl.md
# turn_timer_ctrl

Turn-timer controller for the two-player game datapath. It owns a per-second prescaler and a turn countdown, and hands the single countdown resource alternately to player 0 and player 1. It sequences start, pause, move completion, expiry and acknowledge, and reports the active player, the seconds remaining and a one-cycle `timeUp` pulse. It sits between the game FSM (requester of turns) and the display/LED logic.

## Interface
- `TICKS_PER_SEC`, default 50_000_000: clock cycles per second tick. Must be ≥ 2.
- `TURN_SECS`, default 30: seconds per turn. Legal range 1..63.

Ports:
- `C_50Mhz`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  one-cycle request to begin a match. Honoured only in IDLE.
- `move_done`  in  1  one-cycle pulse: the current player finished the move.
- `pause`  in  1  level; freezes the countdown while high.
- `abort`  in  1  one-cycle pulse; returns the block to IDLE from any state.
- `ack`  in  1  one-cycle pulse; acknowledges an expiry.
- `player`  out  1  active player (0/1).
- `secs_left`  out  6  seconds remaining in the current turn.
- `sec_tick`  out  1  one-cycle pulse on each elapsed second.
- `timeUp`  out  1  one-cycle pulse when `secs_left` reaches 0.
- `running`  out  1  high in RUN and PAUSED.
- `blink`  out  1  low-time warning blink (see Configuration).

## Operation
- States:
  - IDLE: waits for `start`.
  - RUN: counting.
  - PAUSED: `pause` is high, counter frozen.
  - EXPIRED: turn timed out, waiting for `ack`.
- Prescaler width is `$clog2(TICKS_PER_SEC)`. It counts 0..`TICKS_PER_SEC`-1 in RUN only.
- IDLE + `start` → RUN. The same edge sets `player`=0, `secs_left`=`TURN_SECS` and prescaler=0.
- RUN, prescaler = `TICKS_PER_SEC`-1:
  - prescaler wraps to 0, `sec_tick`=1 next cycle, `secs_left` decrements.
  - If `secs_left` was 1, `secs_left` becomes 0, `timeUp`=1 for one cycle, and the state becomes EXPIRED.
- RUN + `move_done`: `player` toggles, `secs_left` reloads to `TURN_SECS`, prescaler clears. No `sec_tick` and no `timeUp` is issued on that edge.
- RUN + `pause`=1 → PAUSED, holding the prescaler and `secs_left`. PAUSED + `pause`=0 → RUN, resuming from the held prescaler value.
  - `move_done` in PAUSED behaves as in RUN: toggle and reload, and the state stays PAUSED.
- EXPIRED: `secs_left` holds 0 and `move_done` is ignored. `ack` → RUN with `player` toggled, `secs_left`=`TURN_SECS` and prescaler=0.
- Priority on the same edge: `abort` > `move_done` > `pause` > prescaler tick.
- `start` outside IDLE is ignored. `ack` outside EXPIRED is ignored.
- `abort` → IDLE with reset values, except that `rst_n` is not asserted.

## Timing
- All outputs are registered.
- Reset (asynchronous, `rst_n`=0): state IDLE, `player`=0, `secs_left`=`TURN_SECS`, prescaler=0, `sec_tick`=0, `timeUp`=0, `running`=0, `blink`=1.
- `start` sampled at edge k: `running`=1 after edge k.
- First `sec_tick` is high for the cycle after edge k+`TICKS_PER_SEC`.
- Uninterrupted turn: `timeUp` rises `TURN_SECS`×`TICKS_PER_SEC` cycles after the start, reload or ack edge. It coincides with the last `sec_tick`.
- `pause` adds exactly the number of cycles it is high to the turn length.
- `rst_n` deassertion is synchronised to `C_50Mhz` internally.

## Configuration
- `TURN_TIMER_BLINK_EN` defined:
  - In RUN with `secs_left` ≤ 5: `blink` = (prescaler < `TICKS_PER_SEC`/2).
  - In EXPIRED: `blink` = 0.
  - Otherwise: `blink` = 1.
- Not defined: `blink` is constant 1 and no comparator logic is synthesised.

## Test plan
All scenarios use `TICKS_PER_SEC`=10, `TURN_SECS`=3. Cycle numbers count from the edge that samples `start`.
- `start`, no further input: `sec_tick` pulses at cycles 10, 20 and 30. At cycle 30, `timeUp`=1 and `secs_left`=0, then the block enters EXPIRED. `ack` at cycle 35 gives `player`=1 and `secs_left`=3.
- `start`, then `move_done` at cycle 15: `player`=1, `secs_left`=3, and the next `sec_tick` comes at cycle 25.
- `start`, then `pause` high for cycles 5..11: first `sec_tick` at cycle 17, `timeUp` at cycle 37.
- `move_done` on the same edge as the final tick (cycle 30): no `timeUp`, `player`=1, `secs_left`=3, state RUN.
- `abort` in EXPIRED: IDLE and `running`=0. A following `ack` has no effect.
- `start` issued while in RUN: ignored.
- `rst_n` pulsed low at cycle 12: all outputs take their reset values immediately, with no clock edge required.
- With `TURN_TIMER_BLINK_EN` defined: `blink` toggles every 5 cycles from the start, since `secs_left` ≤ 5 throughout. Without the macro: `blink` stays 1.
